// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load extraction/extension, write-back source select, RF write port.
// Define WB_RETIRE_CNT_EN to build the committed-instruction counter on retire_count.
module mem_wb_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        in_RegWrite,
    input  logic [1:0]  in_MemToReg,
    input  logic [2:0]  in_LoadType,
    input  logic [4:0]  in_Write_register,
    input  logic [31:0] in_ALU_out,
    input  logic [31:0] in_Mem_data,
    input  logic [31:0] in_PC_link,
    output logic        wb_valid,
    output logic        RegWrite,
    output logic [4:0]  Write_register,
    output logic [31:0] Write_data,
    output logic [31:0] retire_count
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data;
    logic [31:0] wdata_d;

    logic        valid_q;
    logic        regwrite_q;
    logic [4:0]  wreg_q;
    logic [31:0] wdata_q;

    // Formatting happens ahead of the flop so Write_data is a clean register output.
    always_comb begin
        ld_byte = 8'h00;
        case (in_ALU_out[1:0])
            2'b00:   ld_byte = in_Mem_data[7:0];
            2'b01:   ld_byte = in_Mem_data[15:8];
            2'b10:   ld_byte = in_Mem_data[23:16];
            default: ld_byte = in_Mem_data[31:24];
        endcase
        ld_half = in_ALU_out[1] ? in_Mem_data[31:16] : in_Mem_data[15:0];

        load_data = in_Mem_data;
        case (in_LoadType)
            3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
            3'b010:  load_data = {16'h0000, ld_half};
            3'b011:  load_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {24'h000000, ld_byte};
            default: load_data = in_Mem_data;
        endcase

        wdata_d = in_ALU_out;
        case (in_MemToReg)
            2'b01:   wdata_d = load_data;
            2'b10:   wdata_d = in_PC_link;
            default: wdata_d = in_ALU_out;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= 5'd0;
            wdata_q    <= 32'h0;
        end else if (flush) begin
            // Bubble wins over stall; stale write data is harmless with RegWrite low.
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= 5'd0;
        end else if (!stall) begin
            valid_q    <= in_valid;
            regwrite_q <= in_RegWrite;
            wreg_q     <= in_Write_register;
            wdata_q    <= wdata_d;
        end
    end

    assign wb_valid       = valid_q;
    assign RegWrite       = valid_q & regwrite_q & (wreg_q != 5'd0);
    assign Write_register = wreg_q;
    assign Write_data     = wdata_q;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= 32'h0;
        end else if (!stall && !flush && in_valid) begin
            retire_q <= retire_q + 32'd1;
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = 32'h0;
`endif

endmodule
